ctrl_sequencer: RTL and testbench

//  Parametrised microcoded control sequencer for the accumulator processor; drives ALU, bus mux, register loads, PC and RAM strobes.

---
 rtl/ctrl_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: microcoded control sequencer for the accumulator processor.
// Opcodes are decoded by class (IR[7:5]) plus a sub/register index (IR[3:0]).
// IR[4] must be zero for every defined opcode.
// The state register advances on the falling clock edge. The datapath samples
// the strobes on the rising edge.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, undefined
// opcodes or indices enter a sticky TRAP state. When it is not defined, they
// behave as NOP.
module ctrl_sequencer #(
  parameter int IW      = 32,
  parameter int MEM_LAT = 1,
  parameter int NREG    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          z,
  input  logic [IW-1:0] IR,
  input  logic          dram_rdy,
  output logic          dram_req,
  output logic          data_ram_we,
  output logic          inst_ram_we,
  output logic          pc_inc,
  output logic          finish,
  output logic          illegal,
  output logic [7:0]    alu_sel,
  output logic [7:0]    bus_sel,
  output logic [8:0]    reg_sel
);

  localparam logic [7:0] LP_ALU_ADD   = 8'd3;
  localparam logic [7:0] LP_ALU_SUB   = 8'd4;
  localparam logic [7:0] LP_ALU_LOAD  = 8'd8;
  localparam logic [7:0] LP_ALU_NOP   = 8'd9;
  localparam logic [7:0] LP_BUS_DRAM  = 8'd0;
  localparam logic [7:0] LP_BUS_IRAM  = 8'd1;
  localparam logic [7:0] LP_BUS_AC    = 8'd9;
  localparam logic [8:0] LP_LD_IR     = 9'h001;
  localparam logic [8:0] LP_LD_PC     = 9'h100;
  localparam logic [3:0] LP_NREG      = 4'(NREG);
  localparam logic [3:0] LP_LAT_LAST  = 4'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_FETCH_RD, S_FETCH_LD, S_FETCH_INC, S_DECODE,
    S_EXEC, S_OPND_INC, S_OPND_RD, S_OPND_LD,
    S_MEM_REQ, S_MEM_LD, S_JMP_CHK, S_JMP_RD,
    S_JMP_LD, S_JMP_SETTLE, S_HALT, S_TRAP
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  state_t     w_dec_state;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;

  logic [2:0] w_cls;
  logic       w_b4;
  logic [3:0] w_sub;
  logic       w_dec_bad;
  logic       w_wait_done;
  logic       w_jmp_taken;
  logic [8:0] w_reg_onehot;
  logic [7:0] w_bus_reg;

  assign w_cls        = IR[7:5];
  assign w_b4         = IR[4];
  assign w_sub        = IR[3:0];
  assign w_wait_done  = (r_cnt == LP_LAT_LAST);
  // JMPZ is sub 0 and JMPNZ is sub 1. z matters only while the state is JMP_CHK.
  assign w_jmp_taken  = w_sub[0] ? ~z : z;
  // Register loads start at reg_sel bit 1. Register bus sources start at code 2.
  assign w_reg_onehot = 9'b0_0000_0010 << w_sub[2:0];
  assign w_bus_reg    = 8'd2 + {5'b0, w_sub[2:0]};
  assign inst_ram_we  = 1'b0;

  // IR bits above the opcode byte carry no control information.
  generate
    if (IW > 8) begin : g_ir_hi
      logic w_unused_ir_hi;
      assign w_unused_ir_hi = ^IR[IW-1:8];
    end
  endgenerate

  // Classify the opcode into the first post-decode state, or flag it as undefined.
  always_comb begin
    w_dec_state = S_FETCH_RD;
    w_dec_bad   = 1'b0;
    if (w_b4) begin
      w_dec_bad = 1'b1;
    end else begin
      case (w_cls)
        3'd0: begin
          if (w_sub == 4'd0)      w_dec_state = S_FETCH_RD;
          else if (w_sub == 4'd1) w_dec_state = S_HALT;
          else                    w_dec_bad   = 1'b1;
        end
        3'd1: begin
          if (w_sub == 4'd0)      w_dec_state = S_OPND_INC;
          else if (w_sub <= 4'd7) w_dec_state = S_EXEC;
          else                    w_dec_bad   = 1'b1;
        end
        3'd2, 3'd3, 3'd4, 3'd5: begin
          if (w_sub < LP_NREG)    w_dec_state = S_EXEC;
          else                    w_dec_bad   = 1'b1;
        end
        3'd6: begin
          if (w_sub <= 4'd1)      w_dec_state = S_MEM_REQ;
          else                    w_dec_bad   = 1'b1;
        end
        default: begin
          if (w_sub <= 4'd1)      w_dec_state = S_JMP_CHK;
          else                    w_dec_bad   = 1'b1;
        end
      endcase
    end
    if (w_dec_bad) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      w_dec_state = S_TRAP;
`else
      w_dec_state = S_FETCH_RD;
`endif
    end
  end

  // State register and wait-state counter. Both advance on the falling edge and reset asynchronously.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH_RD;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. When enable is low, both the state and the counter hold.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (enable) begin
      case (r_state)
        S_FETCH_RD, S_OPND_RD, S_JMP_RD: begin
          if (w_wait_done) begin
            w_cnt_next = 4'd0;
            case (r_state)
              S_FETCH_RD: w_state_next = S_FETCH_LD;
              S_OPND_RD:  w_state_next = S_OPND_LD;
              default:    w_state_next = S_JMP_LD;
            endcase
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        S_FETCH_LD:   w_state_next = S_FETCH_INC;
        S_FETCH_INC:  w_state_next = S_DECODE;
        S_DECODE:     w_state_next = w_dec_state;
        S_EXEC:       w_state_next = S_FETCH_RD;
        S_OPND_INC:   w_state_next = S_OPND_RD;
        S_OPND_LD:    w_state_next = S_FETCH_RD;
        S_MEM_REQ: begin
          if (dram_rdy) w_state_next = w_sub[0] ? S_FETCH_RD : S_MEM_LD;
        end
        S_MEM_LD:     w_state_next = S_FETCH_RD;
        S_JMP_CHK:    w_state_next = w_jmp_taken ? S_JMP_RD : S_FETCH_RD;
        S_JMP_LD:     w_state_next = S_JMP_SETTLE;
        S_JMP_SETTLE: w_state_next = S_FETCH_RD;
        S_HALT:       w_state_next = S_HALT;
        S_TRAP:       w_state_next = S_TRAP;
        default:      w_state_next = S_FETCH_RD;
      endcase
    end
  end

  // Datapath strobes. dram_req survives a stall so that an open DRAM access stays requested.
  always_comb begin
    dram_req    = 1'b0;
    data_ram_we = 1'b0;
    pc_inc      = 1'b0;
    alu_sel     = LP_ALU_NOP;
    bus_sel     = LP_BUS_IRAM;
    reg_sel     = 9'h000;
    if (r_state == S_MEM_REQ) begin
      dram_req = 1'b1;
      if (enable) begin
        if (w_sub[0]) begin
          data_ram_we = 1'b1;
          bus_sel     = LP_BUS_AC;
        end else begin
          bus_sel     = LP_BUS_DRAM;
        end
      end
    end else if (enable) begin
      case (r_state)
        S_FETCH_LD:   reg_sel = LP_LD_IR;
        S_FETCH_INC,
        S_OPND_INC,
        S_JMP_CHK:    pc_inc  = 1'b1;
        S_OPND_LD:    alu_sel = LP_ALU_LOAD;
        S_MEM_LD: begin
          alu_sel = LP_ALU_LOAD;
          bus_sel = LP_BUS_DRAM;
        end
        S_JMP_LD:     reg_sel = LP_LD_PC;
        S_EXEC: begin
          case (w_cls)
            3'd1: alu_sel = {4'b0, w_sub};
            3'd2: begin
              bus_sel = LP_BUS_AC;
              reg_sel = w_reg_onehot;
            end
            3'd3: begin
              alu_sel = LP_ALU_LOAD;
              bus_sel = w_bus_reg;
            end
            3'd4: begin
              alu_sel = LP_ALU_ADD;
              bus_sel = w_bus_reg;
            end
            3'd5: begin
              alu_sel = LP_ALU_SUB;
              bus_sel = w_bus_reg;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // finish and illegal are status flags. They reflect the terminal state even during a stall.
  assign finish = (r_state == S_HALT) || (r_state == S_TRAP);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed bench for ctrl_sequencer with MEM_LAT=3.
// It steps through each opcode class and compares the packed output vector once per cycle.
module tb_ctrl_sequencer;

  localparam int L = 3;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        z;
  logic [31:0] IR;
  logic        dram_rdy;
  logic        dram_req;
  logic        data_ram_we;
  logic        inst_ram_we;
  logic        pc_inc;
  logic        finish;
  logic        illegal;
  logic [7:0]  alu_sel;
  logic [7:0]  bus_sel;
  logic [8:0]  reg_sel;

  int total = 0;
  int bad   = 0;

  ctrl_sequencer #(.IW(32), .MEM_LAT(L), .NREG(7)) dut (
    .clk(clk), .reset(reset), .enable(enable), .z(z), .IR(IR),
    .dram_rdy(dram_rdy), .dram_req(dram_req), .data_ram_we(data_ram_we),
    .inst_ram_we(inst_ram_we), .pc_inc(pc_inc), .finish(finish),
    .illegal(illegal), .alu_sel(alu_sel), .bus_sel(bus_sel), .reg_sel(reg_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output vector: {req, we, iram_we, pc_inc, finish, illegal, alu, bus, reg}
  function automatic logic [30:0] ov(input int alu, input int bus, input int rs,
                                     input logic pc, input logic req, input logic we,
                                     input logic fin, input logic ill);
    return {req, we, 1'b0, pc, fin, ill, 8'(alu), 8'(bus), 9'(rs)};
  endfunction

  task automatic chk(input string tag, input logic [30:0] exp);
    logic [30:0] obs;
    #1;
    obs = {dram_req, data_ram_we, inst_ram_we, pc_inc, finish, illegal,
           alu_sel, bus_sel, reg_sel};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Move to just after the next state update.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    chk(tag, ov(9, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    reset = 1'b0;
  endtask

  // Fetch: L IRAM wait cycles, then IR load, then PC increment, then decode.
  task automatic fetch(input logic [7:0] op);
    IR = {24'h0, op};
    for (int i = 0; i < L; i++) begin
      chk("fetch_rd", ov(9, 1, 0, 0, 0, 0, 0, 0));
      step();
    end
    chk("fetch_ld", ov(9, 1, 9'h001, 0, 0, 0, 0, 0));
    step();
    chk("fetch_inc", ov(9, 1, 0, 1, 0, 0, 0, 0));
    step();
    chk("decode", ov(9, 1, 0, 0, 0, 0, 0, 0));
    step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; z = 1'b0; dram_rdy = 1'b0; IR = 32'h0;
    repeat (2) @(negedge clk);
    do_reset("reset_idle");

    // A reset pulse during FETCH_LD clears the IR load and restarts the fetch.
    IR = 32'h0;
    for (int i = 0; i < L; i++) begin
      chk("pre_rd", ov(9, 1, 0, 0, 0, 0, 0, 0));
      step();
    end
    chk("pre_ld", ov(9, 1, 9'h001, 0, 0, 0, 0, 0));
    do_reset("rst_mid_fetch_ld");

    // ADD C1: EXEC uses ALU op 3 with C1 (bus code 6) as the operand.
    fetch(8'h84);
    chk("exec_add_c1", ov(3, 6, 0, 0, 0, 0, 0, 0)); step();
    // SUB BI
    fetch(8'hA2);
    chk("exec_sub_bi", ov(4, 4, 0, 0, 0, 0, 0, 0)); step();
    // MVAC AR: AC on the bus, AR load strobe on reg_sel bit 7.
    fetch(8'h46);
    chk("exec_mvac_ar", ov(9, 9, 9'h080, 0, 0, 0, 0, 0)); step();
    // MV DI
    fetch(8'h60);
    chk("exec_mv_di", ov(8, 2, 0, 0, 0, 0, 0, 0)); step();
    // UNARY DEC (sub 2)
    fetch(8'h22);
    chk("exec_dec", ov(2, 1, 0, 0, 0, 0, 0, 0)); step();

    // LDAC immediate
    fetch(8'h20);
    chk("opnd_inc", ov(9, 1, 0, 1, 0, 0, 0, 0)); step();
    for (int i = 0; i < L; i++) begin
      chk("opnd_rd", ov(9, 1, 0, 0, 0, 0, 0, 0));
      step();
    end
    chk("opnd_ld", ov(8, 1, 0, 0, 0, 0, 0, 0)); step();

    // READ: a stall holds dram_req, and dram_rdy is ignored while the stall lasts.
    fetch(8'hC0);
    chk("read_req0", ov(9, 0, 0, 0, 1, 0, 0, 0)); step();
    enable = 1'b0; dram_rdy = 1'b1;
    chk("read_stall", ov(9, 1, 0, 0, 1, 0, 0, 0)); step();
    enable = 1'b1; dram_rdy = 1'b0;
    chk("read_req1", ov(9, 0, 0, 0, 1, 0, 0, 0)); step();
    dram_rdy = 1'b1;
    chk("read_req_rdy", ov(9, 0, 0, 0, 1, 0, 0, 0)); step();
    dram_rdy = 1'b0;
    chk("mem_ld", ov(8, 0, 0, 0, 0, 0, 0, 0)); step();

    // WRITE: with dram_rdy low for 4 cycles, req and we stay asserted for 4+1 cycles.
    fetch(8'hC1);
    for (int i = 0; i < 4; i++) begin
      chk("write_wait", ov(9, 9, 0, 0, 1, 1, 0, 0));
      step();
    end
    dram_rdy = 1'b1;
    chk("write_rdy", ov(9, 9, 0, 0, 1, 1, 0, 0)); step();
    dram_rdy = 1'b0;

    // JMPZ taken. z changes after JMP_CHK must have no effect.
    z = 1'b1;
    fetch(8'hE0);
    chk("jmpz_chk", ov(9, 1, 0, 1, 0, 0, 0, 0)); step();
    z = 1'b0;
    for (int i = 0; i < L; i++) begin
      chk("jmp_rd", ov(9, 1, 0, 0, 0, 0, 0, 0));
      step();
    end
    chk("jmp_ld", ov(9, 1, 9'h100, 0, 0, 0, 0, 0)); step();
    chk("jmp_settle", ov(9, 1, 0, 0, 0, 0, 0, 0)); step();
    // JMPZ not taken
    fetch(8'hE0);
    chk("jmpz_nt_chk", ov(9, 1, 0, 1, 0, 0, 0, 0)); step();
    // JMPNZ taken with z=0
    fetch(8'hE1);
    chk("jmpnz_chk", ov(9, 1, 0, 1, 0, 0, 0, 0)); step();
    for (int i = 0; i < L; i++) begin
      chk("jmpnz_rd", ov(9, 1, 0, 0, 0, 0, 0, 0));
      step();
    end
    chk("jmpnz_ld", ov(9, 1, 9'h100, 0, 0, 0, 0, 0)); step();
    chk("jmpnz_settle", ov(9, 1, 0, 0, 0, 0, 0, 0)); step();
    // JMPNZ not taken with z=1
    z = 1'b1;
    fetch(8'hE1);
    chk("jmpnz_nt_chk", ov(9, 1, 0, 1, 0, 0, 0, 0)); step();
    z = 1'b0;

    // A stall in EXEC idles the strobes. The same EXEC then resumes.
    fetch(8'h84);
    enable = 1'b0;
    chk("exec_stall0", ov(9, 1, 0, 0, 0, 0, 0, 0)); step();
    chk("exec_stall1", ov(9, 1, 0, 0, 0, 0, 0, 0)); step();
    enable = 1'b1;
    chk("exec_resume", ov(3, 6, 0, 0, 0, 0, 0, 0)); step();

    // A reset during a DRAM write drops req and we immediately.
    fetch(8'hC1);
    chk("write_pre_rst", ov(9, 9, 0, 0, 1, 1, 0, 0));
    do_reset("rst_mid_write");

    // Undefined opcode: bit 4 is set.
    fetch(8'h55);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("trap", ov(9, 1, 0, 0, 0, 0, 1, 1));
      step();
    end
    do_reset("rst_from_trap");
`endif

    // Index 7 is beyond NREG=7 and is handled the same way as any undefined opcode.
    fetch(8'h87);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("trap_idx", ov(9, 1, 0, 0, 0, 0, 1, 1)); step();
    do_reset("rst_from_trap_idx");
`endif

    // END halts with finish held.
    fetch(8'h01);
    for (int i = 0; i < 3; i++) begin
      chk("halt", ov(9, 1, 0, 0, 0, 0, 1, 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
